nios_setup_onchip_memory_pipe: RTL and testbench
================================================

NIOS_SETUP_ONCHIP_MEMORY_PIPE -- requirements
Module: nios_setup_onchip_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word address width; depth = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2 cycles.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as the ports clk and reset.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 reset_req  input  1  quiesce request; blocks new accepts on both ports.
REQ-008 address / address2  input  ADDR_WIDTH  port 1 / port 2 word address.
REQ-009 byteenable / byteenable2  input  DATA_WIDTH/8  per-byte write enables.
REQ-010 chipselect / chipselect2  input  1  port select.
REQ-011 read / read2  input  1  read request.
REQ-012 write / write2  input  1  write request.
REQ-013 writedata / writedata2  input  DATA_WIDTH  write data.
REQ-014 readdata / readdata2  output  DATA_WIDTH  read data, valid with readdatavalid.
REQ-015 readdatavalid / readdatavalid2  output  1  one-cycle read-return strobe.
REQ-016 waitrequest / waitrequest2  output  1  combinational stall; request not accepted while high.

Function
REQ-017 Request accepted on a port when chipselect & (read | write) & ~waitrequest at a rising clk edge.
REQ-018 read and write both high on one port SHALL be treated as write only; no readdatavalid.
REQ-019 Accepted write SHALL update only bytes whose byteenable bit is 1; byteenable all-zero is a no-op write.
REQ-020 Accepted read in cycle N SHALL give readdatavalid=1 and readdata in cycle N+READ_LATENCY, exactly one cycle, in issue order; one read acceptable every cycle (fully pipelined).
REQ-021 readdata SHALL hold its last value while readdatavalid=0.
REQ-022 Mixed-port read-during-write to same address, same cycle: read returns OLD data.
REQ-023 Write collision: both ports accept-eligible writes to same address same cycle -> port 1 writes, waitrequest2=1 that cycle; port 2 write accepted next cycle (port 2 value final).
REQ-024 Collision check SHALL compare full address only; byteenable overlap ignored.
REQ-025 Port 1 waitrequest SHALL be 1 only when reset_req=1.
REQ-026 reset_req=1 SHALL force waitrequest=waitrequest2=1; already-accepted reads still complete at their scheduled cycle.
REQ-027 Reads on distinct or equal addresses from both ports in same cycle SHALL both be accepted.
REQ-028 Address wrap: addresses are ADDR_WIDTH-bit; no out-of-range condition exists.

Reset
REQ-029 reset=1 SHALL immediately force readdatavalid=readdatavalid2=0, readdata=readdata2=0, and discard all in-flight reads.
REQ-030 Memory contents SHALL NOT be cleared by reset; contents after power-up undefined.
REQ-031 First request accepted on the first rising clk edge after reset deasserts.

Verification
REQ-032 Write 0xDEADBEEF to addr 0x010 via port 1, then read addr 0x010 via port 2 -> readdata2=0xDEADBEEF, readdatavalid2 exactly READ_LATENCY cycles after accept.
REQ-033 Addr 0x020 holds 0x11223344; port 1 write 0xAABBCCDD byteenable 0b0101 -> subsequent read 0x11BB33DD.
REQ-034 Same cycle: port 1 writes 0x1 and port 2 writes 0x2 to addr 0x030 -> waitrequest2=1 one cycle, waitrequest=0, final read of 0x030 = 0x2.
REQ-035 Addr 0x040 holds 0x5; same cycle port 1 reads 0x040, port 2 writes 0x9 -> port 1 returns 0x5; next read returns 0x9.
REQ-036 Back-to-back reads addr 0..7 on port 1, READ_LATENCY=2 -> 8 consecutive readdatavalid cycles, data in address order.
REQ-037 Read accepted, reset asserted before return -> readdatavalid stays 0, readdata=0; prior-written contents intact after reset.

Source files
------------

// File: rtl/nios_setup_onchip_memory_pipe_if.sv
// One Avalon-MM style slave port of the on-chip memory: request, write data,
// pipelined read return and combinational stall.
interface nios_setup_onchip_memory_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) ();

   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic                    chipselect;
   logic                    read;
   logic                    write;
   logic [DATA_WIDTH-1:0]   writedata;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdatavalid;
   logic                    waitrequest;

   modport master (
      output address,
      output byteenable,
      output chipselect,
      output read,
      output write,
      output writedata,
      input  readdata,
      input  readdatavalid,
      input  waitrequest
   );

   modport slave (
      input  address,
      input  byteenable,
      input  chipselect,
      input  read,
      input  write,
      input  writedata,
      output readdata,
      output readdatavalid,
      output waitrequest
   );

endinterface

// File: rtl/nios_setup_onchip_memory_pipe.sv
// Dual-port on-chip RAM with byte enables, fully pipelined reads (latency 1 or 2)
// and same-address write collision arbitration in favour of port 1.
module nios_setup_onchip_memory_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic reset_req,
   nios_setup_onchip_memory_pipe_if.slave port1,
   nios_setup_onchip_memory_pipe_if.slave port2
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 1 << ADDR_WIDTH;

   // Handshake: a port's request is taken at a rising clk edge when
   // chipselect & (read | write) & ~waitrequest. read+write together is a
   // write only. readdatavalid is a one-cycle strobe READ_LATENCY cycles after
   // the accepting edge; readdata holds between strobes.

   logic [ADDR_WIDTH-1:0] addr     [2];
   logic [NUM_BYTES-1:0]  be       [2];
   logic                  cs       [2];
   logic                  rd       [2];
   logic                  wr       [2];
   logic [DATA_WIDTH-1:0] wdata    [2];
   logic                  wait_req [2];
   logic                  acc      [2];
   logic                  acc_w    [2];
   logic                  acc_r    [2];
   logic                  collide;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DATA_WIDTH-1:0] rd_q      [2];
   logic                  rv_q      [2];
   logic [DATA_WIDTH-1:0] out_data  [2];
   logic                  out_valid [2];

   always_comb begin
      addr[0]  = port1.address;
      addr[1]  = port2.address;
      be[0]    = port1.byteenable;
      be[1]    = port2.byteenable;
      cs[0]    = port1.chipselect;
      cs[1]    = port2.chipselect;
      rd[0]    = port1.read;
      rd[1]    = port2.read;
      wr[0]    = port1.write;
      wr[1]    = port2.write;
      wdata[0] = port1.writedata;
      wdata[1] = port2.writedata;
   end

   // Only full-address equality matters; disjoint byte lanes still collide.
   always_comb begin
      collide = ~reset_req & cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
      wait_req[0] = reset_req;
      wait_req[1] = reset_req | collide;
      for (int p = 0; p < 2; p++) begin
         acc[p]   = cs[p] & (rd[p] | wr[p]) & ~wait_req[p];
         acc_w[p] = acc[p] & wr[p];
         acc_r[p] = acc[p] & rd[p] & ~wr[p];
      end
   end

   // Storage is never reset; contents survive a reset pulse.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (acc_w[p]) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
               if (be[p][b]) begin
                  mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
               end
            end
         end
      end
   end

   // The array read samples pre-edge contents, so a read that meets a write
   // from the other port at the same address returns the old word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            rd_q[p] <= '0;
            rv_q[p] <= 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            rv_q[p] <= acc_r[p];
            if (acc_r[p]) begin
               rd_q[p] <= mem[addr[p]];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] od_q [2];
         logic                  ov_q [2];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int p = 0; p < 2; p++) begin
                  od_q[p] <= '0;
                  ov_q[p] <= 1'b0;
               end
            end else begin
               for (int p = 0; p < 2; p++) begin
                  ov_q[p] <= rv_q[p];
                  if (rv_q[p]) begin
                     od_q[p] <= rd_q[p];
                  end
               end
            end
         end

         always_comb begin
            for (int p = 0; p < 2; p++) begin
               out_data[p]  = od_q[p];
               out_valid[p] = ov_q[p];
            end
         end
      end else begin : g_lat1
         always_comb begin
            for (int p = 0; p < 2; p++) begin
               out_data[p]  = rd_q[p];
               out_valid[p] = rv_q[p];
            end
         end
      end
   endgenerate

   assign port1.waitrequest   = wait_req[0];
   assign port2.waitrequest   = wait_req[1];
   assign port1.readdata      = out_data[0];
   assign port2.readdata      = out_data[1];
   assign port1.readdatavalid = out_valid[0];
   assign port2.readdatavalid = out_valid[1];

endmodule

// File: tb/tb_nios_setup_onchip_memory_pipe.sv
// Directed bench: one instance with READ_LATENCY=1 and one with READ_LATENCY=2,
// driven with identical stimulus and checked against hand-computed read data.
module tb_nios_setup_onchip_memory_pipe;

   localparam logic [1:0] OP_IDLE = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b10;
   localparam logic [1:0] OP_RW   = 2'b11;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] edge_n;
   } rd_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        reset_req;
   logic [11:0] a1, a2;
   logic [3:0]  be1, be2;
   logic        cs1, cs2, rd1, rd2, wr1, wr2;
   logic [31:0] wd1, wd2;

   int          ecnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   rd_t         q_a1[$];
   rd_t         q_a2[$];
   rd_t         q_b1[$];
   rd_t         q_b2[$];
   logic [31:0] last_rd [4];

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   nios_setup_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) i_a1 ();
   nios_setup_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) i_a2 ();
   nios_setup_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) i_b1 ();
   nios_setup_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) i_b2 ();

   assign i_a1.address = a1;   assign i_b1.address = a1;
   assign i_a1.byteenable = be1; assign i_b1.byteenable = be1;
   assign i_a1.chipselect = cs1; assign i_b1.chipselect = cs1;
   assign i_a1.read = rd1;     assign i_b1.read = rd1;
   assign i_a1.write = wr1;    assign i_b1.write = wr1;
   assign i_a1.writedata = wd1; assign i_b1.writedata = wd1;
   assign i_a2.address = a2;   assign i_b2.address = a2;
   assign i_a2.byteenable = be2; assign i_b2.byteenable = be2;
   assign i_a2.chipselect = cs2; assign i_b2.chipselect = cs2;
   assign i_a2.read = rd2;     assign i_b2.read = rd2;
   assign i_a2.write = wr2;    assign i_b2.write = wr2;
   assign i_a2.writedata = wd2; assign i_b2.writedata = wd2;

   nios_setup_onchip_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(1)) dut_a (
      .clk(clk), .reset(reset), .reset_req(reset_req), .port1(i_a1), .port2(i_a2)
   );

   nios_setup_onchip_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(2)) dut_b (
      .clk(clk), .reset(reset), .reset_req(reset_req), .port1(i_b1), .port2(i_b2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard: one expected queue per port per instance
   task automatic mon_one(input string tag, input int ch, input int lat,
                          input logic v, input logic [31:0] d);
      rd_t  e;
      logic have;
      have = 1'b0;
      e    = '0;
      if (reset) begin
         check_eq({tag, "_rst_valid"}, {31'b0, v}, 32'h0);
         check_eq({tag, "_rst_data"}, d, 32'h0);
         last_rd[ch] = 32'h0;
         return;
      end
      if (v) begin
         case (ch)
            0: if (q_a1.size() != 0) begin e = q_a1.pop_front(); have = 1'b1; end
            1: if (q_a2.size() != 0) begin e = q_a2.pop_front(); have = 1'b1; end
            2: if (q_b1.size() != 0) begin e = q_b1.pop_front(); have = 1'b1; end
            default: if (q_b2.size() != 0) begin e = q_b2.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            check_eq({tag, "_spurious_valid"}, {31'b0, v}, 32'h0);
         end else begin
            check_eq({tag, "_data"}, d, e.data);
            check_eq({tag, "_latency"}, ecnt, e.edge_n + lat - 1);
            last_rd[ch] = e.data;
         end
      end else begin
         check_eq({tag, "_hold"}, d, last_rd[ch]);
      end
   endtask

   always @(negedge clk) begin
      mon_one("a1", 0, 1, i_a1.readdatavalid, i_a1.readdata);
      mon_one("a2", 1, 1, i_a2.readdatavalid, i_a2.readdata);
      mon_one("b1", 2, 2, i_b1.readdatavalid, i_b1.readdata);
      mon_one("b2", 3, 2, i_b2.readdatavalid, i_b2.readdata);
   end

   // driver: one bus cycle on both ports; e1/e2 are the expected read data,
   // ew2 the expected port 2 stall for this cycle
   task automatic bus(input logic [1:0] o1, input logic [11:0] ad1, input logic [3:0] b1,
                      input logic [31:0] d1, input logic [31:0] e1,
                      input logic [1:0] o2, input logic [11:0] ad2, input logic [3:0] b2,
                      input logic [31:0] d2, input logic [31:0] e2, input logic ew2);
      cs1 = (o1 != OP_IDLE); rd1 = o1[0]; wr1 = o1[1]; a1 = ad1; be1 = b1; wd1 = d1;
      cs2 = (o2 != OP_IDLE); rd2 = o2[0]; wr2 = o2[1]; a2 = ad2; be2 = b2; wd2 = d2;
      #1;
      check_eq("a_wait1", {31'b0, i_a1.waitrequest}, {31'b0, reset_req});
      check_eq("b_wait1", {31'b0, i_b1.waitrequest}, {31'b0, reset_req});
      check_eq("a_wait2", {31'b0, i_a2.waitrequest}, {31'b0, ew2});
      check_eq("b_wait2", {31'b0, i_b2.waitrequest}, {31'b0, ew2});
      @(posedge clk);
      #1;
      if (o1 == OP_RD && !reset_req) begin
         q_a1.push_back({e1, ecnt[31:0]});
         q_b1.push_back({e1, ecnt[31:0]});
      end
      if (o2 == OP_RD && !reset_req && !ew2) begin
         q_a2.push_back({e2, ecnt[31:0]});
         q_b2.push_back({e2, ecnt[31:0]});
      end
   endtask

   task automatic idle_cycle();
      bus(OP_IDLE, 12'h0, 4'h0, 32'h0, 32'h0, OP_IDLE, 12'h0, 4'h0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; reset_req = 1'b0;
      cs1 = 0; rd1 = 0; wr1 = 0; a1 = 0; be1 = 0; wd1 = 0;
      cs2 = 0; rd2 = 0; wr2 = 0; a2 = 0; be2 = 0; wd2 = 0;
      for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // first edge after reset accepts; write then read back on the other port
      bus(OP_WR, 12'h010, 4'hF, 32'hDEADBEEF, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_IDLE, 0, 0, 0, 0, OP_RD, 12'h010, 0, 0, 32'hDEADBEEF, 1'b0);

      // byte enables 0101, then dual reads of the same address
      bus(OP_WR, 12'h020, 4'hF, 32'h11223344, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_WR, 12'h020, 4'h5, 32'hAABBCCDD, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_RD, 12'h020, 0, 0, 32'h11BB33DD, OP_RD, 12'h020, 0, 0, 32'h11BB33DD, 1'b0);

      // write collision: port 1 first, port 2 retried and final
      bus(OP_WR, 12'h030, 4'hF, 32'h1, 0, OP_WR, 12'h030, 4'hF, 32'h2, 0, 1'b1);
      bus(OP_IDLE, 0, 0, 0, 0, OP_WR, 12'h030, 4'hF, 32'h2, 0, 1'b0);
      bus(OP_RD, 12'h030, 0, 0, 32'h2, OP_RD, 12'h010, 0, 0, 32'hDEADBEEF, 1'b0);

      // collision with disjoint byte lanes still stalls port 2
      bus(OP_WR, 12'h070, 4'hF, 32'h0, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_WR, 12'h070, 4'h3, 32'h0000AAAA, 0, OP_WR, 12'h070, 4'hC, 32'hBBBB0000, 0, 1'b1);
      bus(OP_IDLE, 0, 0, 0, 0, OP_WR, 12'h070, 4'hC, 32'hBBBB0000, 0, 1'b0);
      bus(OP_IDLE, 0, 0, 0, 0, OP_RD, 12'h070, 0, 0, 32'hBBBBAAAA, 1'b0);

      // mixed-port read during write returns old data
      bus(OP_WR, 12'h040, 4'hF, 32'h5, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_RD, 12'h040, 0, 0, 32'h5, OP_WR, 12'h040, 4'hF, 32'h9, 0, 1'b0);
      bus(OP_RD, 12'h040, 0, 0, 32'h9, OP_IDLE, 0, 0, 0, 0, 1'b0);

      // read+write on one port is a write with no return
      bus(OP_RW, 12'h050, 4'hF, 32'h77, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_RD, 12'h050, 0, 0, 32'h77, OP_IDLE, 0, 0, 0, 0, 1'b0);

      // all-zero byteenable leaves the word untouched
      bus(OP_WR, 12'h060, 4'hF, 32'hCAFEF00D, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_WR, 12'h060, 4'h0, 32'hFFFFFFFF, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_IDLE, 0, 0, 0, 0, OP_RD, 12'h060, 0, 0, 32'hCAFEF00D, 1'b0);

      // top address, then fill 0..7 from both ports and stream reads back
      bus(OP_WR, 12'hFFF, 4'hF, 32'h0BADF00D, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         bus(OP_WR, 12'(i), 4'hF, 32'h100 + 32'(i), 0, OP_WR, 12'(i + 4), 4'hF, 32'h104 + 32'(i), 0, 1'b0);
      for (int i = 0; i < 8; i++)
         bus(OP_RD, 12'(i), 0, 0, 32'h100 + 32'(i), OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_RD, 12'hFFF, 0, 0, 32'h0BADF00D, OP_IDLE, 0, 0, 0, 0, 1'b0);

      // reset_req stalls both ports; accepted reads still return
      bus(OP_WR, 12'h080, 4'hF, 32'h12345678, 0, OP_IDLE, 0, 0, 0, 0, 1'b0);
      bus(OP_RD, 12'h010, 0, 0, 32'hDEADBEEF, OP_RD, 12'h020, 0, 0, 32'h11BB33DD, 1'b0);
      reset_req = 1'b1;
      bus(OP_RD, 12'h080, 0, 0, 0, OP_WR, 12'h010, 4'hF, 32'h0, 0, 1'b1);
      bus(OP_WR, 12'h010, 4'hF, 32'h0, 0, OP_WR, 12'h020, 4'hF, 32'h0, 0, 1'b1);
      reset_req = 1'b0;
      bus(OP_RD, 12'h010, 0, 0, 32'hDEADBEEF, OP_RD, 12'h020, 0, 0, 32'h11BB33DD, 1'b0);

      // reset with reads in flight: returns discarded, contents kept
      bus(OP_RD, 12'h080, 0, 0, 32'h12345678, OP_RD, 12'h010, 0, 0, 32'hDEADBEEF, 1'b0);
      reset = 1'b1;
      q_a1.delete(); q_a2.delete(); q_b1.delete(); q_b2.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      bus(OP_RD, 12'h080, 0, 0, 32'h12345678, OP_RD, 12'h010, 0, 0, 32'hDEADBEEF, 1'b0);

      repeat (4) idle_cycle();
      check_eq("drain_a1", q_a1.size(), 32'h0);
      check_eq("drain_a2", q_a2.size(), 32'h0);
      check_eq("drain_b1", q_b1.size(), 32'h0);
      check_eq("drain_b2", q_b2.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
